// File: rtl/pwm_pkg.sv
// ---------------------------------------------------------------------------------------------
// pwm_pkg: shared definitions for the PWM channel.
//   - Bit positions and widths of the 32-bit control word and 8-bit status word.
//   - Channel state enum.
//   - Decoded control-field struct, shadow struct and helper functions.
// ---------------------------------------------------------------------------------------------
package pwm_pkg;

   // Control word layout
   localparam int unsigned CtrlUsedW = 26;  // bits [31:26] are reserved
   localparam int unsigned FieldW    = 8;
   localparam int unsigned DutyLsb   = 0;
   localparam int unsigned TopLsb    = 8;
   localparam int unsigned PrescLsb  = 16;
   localparam int unsigned EnableBit = 24;
   localparam int unsigned InvertBit = 25;

   // Status word layout
   localparam int unsigned StatusW        = 8;
   localparam int unsigned StatRunningBit = 0;
   localparam int unsigned StatPendingBit = 1;
   localparam int unsigned StatClampedBit = 2;
   localparam int unsigned StatLevelBit   = 3;
   localparam int unsigned StatWrapLsb    = 4;

   typedef enum logic [1:0] {
      StIdle     = 2'd0,
      StRun      = 2'd1,
      StStopping = 2'd2
   } pwm_state_e;

   // Fields decoded from the live control word
   typedef struct packed {
      logic [FieldW-1:0] duty;
      logic [FieldW-1:0] top;
      logic [FieldW-1:0] presc;
      logic              enable;
      logic              invert;
   } ctrl_fields_t;

   // Configuration actually in use by the counters; enable is never shadowed
   typedef struct packed {
      logic [FieldW-1:0] duty;
      logic [FieldW-1:0] top;
      logic [FieldW-1:0] presc;
      logic              invert;
   } shadow_t;

   function automatic ctrl_fields_t pwm_decode(input logic [CtrlUsedW-1:0] ctrl);
      ctrl_fields_t f;
      f.duty   = ctrl[DutyLsb  +: FieldW];
      f.top    = ctrl[TopLsb   +: FieldW];
      f.presc  = ctrl[PrescLsb +: FieldW];
      f.enable = ctrl[EnableBit];
      f.invert = ctrl[InvertBit];
      return f;
   endfunction

   function automatic shadow_t pwm_to_shadow(input ctrl_fields_t f);
      shadow_t s;
      s.duty   = f.duty;
      s.top    = f.top;
      s.presc  = f.presc;
      s.invert = f.invert;
      return s;
   endfunction

   // True when the live configuration differs from the shadow (enable excluded)
   function automatic logic pwm_cfg_differs(input ctrl_fields_t f, input shadow_t s);
      return (f.duty != s.duty) || (f.top != s.top) || (f.presc != s.presc) ||
             (f.invert != s.invert);
   endfunction

   // duty == top+1 is an exact 100% setting; only values beyond that are clamped
   function automatic logic pwm_duty_clamped(input logic [FieldW-1:0] duty,
                                             input logic [FieldW-1:0] top);
      logic [FieldW:0] top_p1;
      top_p1 = {1'b0, top} + 1'b1;
      return {1'b0, duty} > top_p1;
   endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// ---------------------------------------------------------------------------------------------
// pwm_prescaler: clock prescaler emitting one tick every presc_i+1 enabled clocks.
//   clk_i    : clock
//   rst_i    : synchronous active-high reset
//   en_i     : count enable; while low the counter is held at zero
//   presc_i  : terminal count (tick when counter equals it)
//   tick_o   : combinational tick, high on the clock where the counter is at terminal count
// ---------------------------------------------------------------------------------------------
module pwm_prescaler #(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             en_i,
   input  logic [CNT_W-1:0] presc_i,
   output logic             tick_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      tick_o = en_i && (cnt_q == presc_i);
      cnt_d  = cnt_q;
      if (!en_i) begin
         cnt_d = '0;
      end else if (tick_o) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/pwm_channel.sv
// ---------------------------------------------------------------------------------------------
// pwm_channel: single glitch-free PWM channel driven by a 32-bit control PIO word.
//   clk_clk           : system clock
//   reset_reset       : synchronous active-high reset
//   pwm_ctrl_export   : [7:0] duty, [15:8] top, [23:16] presc, [24] enable, [25] invert
//   pwm_status_export : [0] running, [1] update_pending, [2] clamped, [3] level, [7:4] wrap_cnt
//   pwm_out           : registered PWM output
//   period_irq        : one-cycle pulse on the cycle after each period boundary while running
// Configuration is shadowed and only reloaded at period boundaries, so a CPU write never
// produces a runt pulse.
// ---------------------------------------------------------------------------------------------
module pwm_channel
   import pwm_pkg::*;
#(
   parameter int unsigned CNT_W  = 8,
   parameter int unsigned WRAP_W = 4
) (
   input  logic         clk_clk,
   input  logic         reset_reset,
   input  logic [31:0]  pwm_ctrl_export,
   output logic [7:0]   pwm_status_export,
   output logic         pwm_out,
   output logic         period_irq
);

   ctrl_fields_t     cfg;
   pwm_state_e       state_q, state_d;
   shadow_t          sh_q, sh_d;
   logic [CNT_W-1:0] per_cnt_q, per_cnt_d;
   logic [WRAP_W-1:0] wrap_cnt_q, wrap_cnt_d;
   logic             pending_q, pending_d;
   logic             pwm_q, pwm_d;
   logic             irq_q, irq_d;

   logic             running;
   logic             tick;
   logic             boundary;
   logic             active;
   logic             clamped;
   logic             unused_rsvd;

   assign cfg         = pwm_decode(pwm_ctrl_export[CtrlUsedW-1:0]);
   assign unused_rsvd = ^pwm_ctrl_export[31:CtrlUsedW];
   assign running     = (state_q != StIdle);

   pwm_prescaler #(
      .CNT_W(CNT_W)
   ) u_prescaler (
      .clk_i  (clk_clk),
      .rst_i  (reset_reset),
      .en_i   (running),
      .presc_i(CNT_W'(sh_q.presc)),
      .tick_o (tick)
   );

   assign boundary = running && tick && (per_cnt_q == CNT_W'(sh_q.top));
   assign active   = (per_cnt_q < CNT_W'(sh_q.duty));
   assign clamped  = pwm_duty_clamped(sh_q.duty, sh_q.top);

   // Next-state, counters and shadow
   always_comb begin
      state_d    = state_q;
      sh_d       = sh_q;
      per_cnt_d  = per_cnt_q;
      wrap_cnt_d = wrap_cnt_q;

      if (running && tick) begin
         per_cnt_d = boundary ? '0 : per_cnt_q + 1'b1;
      end
      if (boundary) begin
         wrap_cnt_d = wrap_cnt_q + 1'b1;
      end

      unique case (state_q)
         StIdle: begin
            if (cfg.enable) begin
               sh_d       = pwm_to_shadow(cfg);
               per_cnt_d  = '0;
               wrap_cnt_d = '0;
               state_d    = StRun;
            end
         end
         StRun: begin
            if (boundary) begin
               sh_d = pwm_to_shadow(cfg);
            end
            // An enable drop on a boundary still runs one full period on the fresh shadow
            if (!cfg.enable) begin
               state_d = StStopping;
            end
         end
         StStopping: begin
            if (boundary) begin
               state_d = StIdle;
            end else if (cfg.enable) begin
               state_d = StRun;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Registered outputs
   always_comb begin
      // Compared against the next shadow so a write landing on a boundary never flags pending
      pending_d = (state_d == StRun) && pwm_cfg_differs(cfg, sh_d);
      // Idle drives the inactive level straight from the live invert bit
      pwm_d     = running ? (active ^ sh_q.invert) : cfg.invert;
      irq_d     = boundary;
   end

   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         state_q    <= StIdle;
         sh_q       <= '0;
         per_cnt_q  <= '0;
         wrap_cnt_q <= '0;
         pending_q  <= 1'b0;
         pwm_q      <= 1'b0;
         irq_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         sh_q       <= sh_d;
         per_cnt_q  <= per_cnt_d;
         wrap_cnt_q <= wrap_cnt_d;
         pending_q  <= pending_d;
         pwm_q      <= pwm_d;
         irq_q      <= irq_d;
      end
   end

   always_comb begin
      pwm_status_export                            = '0;
      pwm_status_export[StatRunningBit]            = running;
      pwm_status_export[StatPendingBit]            = pending_q;
      pwm_status_export[StatClampedBit]            = clamped;
      pwm_status_export[StatLevelBit]              = pwm_q;
      pwm_status_export[StatWrapLsb +: WRAP_W]     = wrap_cnt_q;
   end

   assign pwm_out    = pwm_q;
   assign period_irq = irq_q;

endmodule

// File: tb/tb_pwm_channel.sv
// ---------------------------------------------------------------------------------------------
// tb_pwm_channel: directed scenarios plus randomized control writes, every cycle compared
// against a period-arithmetic reference model.
// ---------------------------------------------------------------------------------------------
module tb_pwm_channel;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] ctrl;
   logic [7:0]  status;
   logic        pwm;
   logic        irq;

   always #5 clk = ~clk;

   pwm_channel #(
      .CNT_W (8),
      .WRAP_W(4)
   ) dut (
      .clk_clk          (clk),
      .reset_reset      (rst),
      .pwm_ctrl_export  (ctrl),
      .pwm_status_export(status),
      .pwm_out          (pwm),
      .period_irq       (irq)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: position in the period measured in clocks
   int   m_state;  // 0 idle, 1 run, 2 stopping
   int   m_clk;
   int   m_duty, m_top, m_presc, m_wrap;
   bit   m_inv;
   bit   e_pwm, e_irq, e_pend;
   logic [7:0] e_status;

   function automatic logic [31:0] mk(input int duty, input int top, input int presc,
                                      input bit en, input bit inv);
      return {6'b0, inv, en, 8'(presc), 8'(top), 8'(duty)};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_load(input logic [31:0] c);
      m_duty  = int'(c[7:0]);
      m_top   = int'(c[15:8]);
      m_presc = int'(c[23:16]);
      m_inv   = c[25];
   endtask

   task automatic model_step(input logic [31:0] c, input bit r);
      int plen;
      bit bnd;
      if (r) begin
         m_state = 0; m_clk = 0; m_duty = 0; m_top = 0; m_presc = 0; m_inv = 0; m_wrap = 0;
         e_pwm = 0; e_irq = 0; e_pend = 0;
      end else begin
         plen  = (m_top + 1) * (m_presc + 1);
         bnd   = (m_state != 0) && (m_clk == plen - 1);
         e_pwm = (m_state != 0) ? (((m_clk / (m_presc + 1)) < m_duty) ^ m_inv) : c[25];
         e_irq = bnd;
         if (m_state != 0) begin
            m_clk = bnd ? 0 : m_clk + 1;
            if (bnd) m_wrap = (m_wrap + 1) % 16;
         end
         case (m_state)
            0: if (c[24]) begin
               model_load(c);
               m_clk = 0; m_wrap = 0; m_state = 1;
            end
            1: begin
               if (bnd) model_load(c);
               if (!c[24]) m_state = 2;
            end
            default: begin
               if (bnd) m_state = 0;
               else if (c[24]) m_state = 1;
            end
         endcase
         e_pend = (m_state == 1) && ((int'(c[7:0]) != m_duty) || (int'(c[15:8]) != m_top) ||
                  (int'(c[23:16]) != m_presc) || (c[25] != m_inv));
      end
      e_status = {4'(m_wrap), e_pwm, (m_duty > m_top + 1), e_pend, (m_state != 0)};
   endtask

   // Drive inputs, clock once, advance the model and compare all outputs
   task automatic cycle(input logic [31:0] c, input bit r);
      ctrl = c;
      rst  = r;
      @(posedge clk);
      model_step(c, r);
      #1;
      check("pwm_out", 32'(pwm), 32'(e_pwm));
      check("period_irq", 32'(irq), 32'(e_irq));
      check("status", 32'(status), 32'(e_status));
   endtask

   initial begin
      logic [31:0] c;
      int hi, lo, nirq;

      // Reset state
      cycle(32'h0, 1'b1);
      cycle(32'h0, 1'b1);
      check("lit_reset_status", 32'(status), 32'h0);
      check("lit_reset_pwm", 32'(pwm), 32'h0);

      // Basic duty 3/10, no prescale
      c = mk(3, 9, 0, 1, 0);
      cycle(c, 1'b0);
      hi = 0; nirq = 0;
      for (int i = 0; i < 40; i++) begin
         cycle(c, 1'b0);
         hi += int'(pwm);
         nirq += int'(irq);
      end
      check("lit_basic_high", 32'(hi), 32'd12);
      check("lit_basic_irq", 32'(nirq), 32'd4);
      check("lit_basic_wrap", 32'(status[7:4]), 32'd4);
      check("lit_basic_running", 32'(status[0]), 32'd1);

      // Mid-period update to duty 8 at per_cnt 5
      for (int i = 0; i < 5; i++) cycle(c, 1'b0);
      c = mk(8, 9, 0, 1, 0);
      cycle(c, 1'b0);
      check("lit_update_pending", 32'(status[1]), 32'd1);
      for (int i = 0; i < 24; i++) cycle(c, 1'b0);
      check("lit_update_cleared", 32'(status[1]), 32'd0);

      // Graceful stop at per_cnt 2
      cycle(32'h0, 1'b1);
      c = mk(3, 9, 0, 1, 0);
      for (int i = 0; i < 3; i++) cycle(c, 1'b0);
      c[24] = 1'b0;
      for (int i = 0; i < 12; i++) cycle(c, 1'b0);
      check("lit_stop_idle", 32'(status[0]), 32'd0);

      // Stop then re-enable at per_cnt 6
      c[24] = 1'b1;
      for (int i = 0; i < 3; i++) cycle(c, 1'b0);
      c[24] = 1'b0;
      for (int i = 0; i < 4; i++) cycle(c, 1'b0);
      c[24] = 1'b1;
      for (int i = 0; i < 20; i++) cycle(c, 1'b0);
      check("lit_reenable_running", 32'(status[0]), 32'd1);

      // Prescale and invert
      cycle(32'h0, 1'b1);
      c = mk(2, 4, 3, 0, 1);
      cycle(c, 1'b0);
      check("lit_idle_invert", 32'(pwm), 32'd1);
      c[24] = 1'b1;
      cycle(c, 1'b0);
      lo = 0;
      for (int i = 0; i < 20; i++) begin
         cycle(c, 1'b0);
         lo += int'(!pwm);
      end
      check("lit_presc_low", 32'(lo), 32'd8);

      // Clamp: duty 20, top 9
      cycle(32'h0, 1'b1);
      c = mk(20, 9, 0, 1, 0);
      cycle(c, 1'b0);
      hi = 0;
      for (int i = 0; i < 25; i++) begin
         cycle(c, 1'b0);
         hi += int'(pwm);
      end
      check("lit_clamp_high", 32'(hi), 32'd25);
      check("lit_clamp_flag", 32'(status[2]), 32'd1);

      // duty 0: constant inactive
      cycle(32'h0, 1'b1);
      c = mk(0, 9, 0, 1, 0);
      cycle(c, 1'b0);
      hi = 0;
      for (int i = 0; i < 20; i++) begin
         cycle(c, 1'b0);
         hi += int'(pwm);
      end
      check("lit_zero_high", 32'(hi), 32'd0);

      // top 0, duty 1: constant active, irq every tick
      cycle(32'h0, 1'b1);
      c = mk(1, 0, 0, 1, 0);
      cycle(c, 1'b0);
      hi = 0; nirq = 0;
      for (int i = 0; i < 10; i++) begin
         cycle(c, 1'b0);
         hi += int'(pwm);
         nirq += int'(irq);
      end
      check("lit_top0_high", 32'(hi), 32'd10);
      check("lit_top0_irq", 32'(nirq), 32'd10);
      check("lit_top0_clamp", 32'(status[2]), 32'd0);

      // Reset mid-operation with enable held
      cycle(32'h0, 1'b1);
      c = mk(3, 9, 0, 1, 0);
      for (int i = 0; i < 5; i++) cycle(c, 1'b0);
      cycle(c, 1'b1);
      check("lit_midreset_status", 32'(status), 32'h0);
      check("lit_midreset_pwm", 32'(pwm), 32'h0);
      for (int i = 0; i < 15; i++) cycle(c, 1'b0);
      check("lit_midreset_wrap", 32'(status[7:4]), 32'd1);

      // Randomized control writes, enable toggles, reserved-bit noise and rare resets
      c = mk($urandom_range(0, 10), $urandom_range(0, 7), $urandom_range(0, 3), 1, 0);
      for (int i = 0; i < 4000; i++) begin
         int roll;
         roll = int'($urandom_range(0, 29));
         if (roll == 0) begin
            c[7:0]   = 8'($urandom_range(0, 10));
            c[15:8]  = 8'($urandom_range(0, 7));
            c[23:16] = 8'($urandom_range(0, 3));
            c[25]    = 1'($urandom_range(0, 1));
         end else if (roll == 1) begin
            c[24] = ~c[24];
         end else if (roll == 2) begin
            c[31:26] = 6'($urandom);
         end
         cycle(c, $urandom_range(0, 299) == 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
